// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared word width, FSM encoding and cooldown constant for the CORDIC initiator
package cordic_pkg;

  localparam int FLOAT_DATA_WIDTH = 32;
  localparam int COOLDOWN_MIN     = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    COOLDOWN  = 2'd2,
    HOLD      = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through read port
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/cordic_batch_initiator.sv
// rtl/cordic_batch_initiator.sv - buffers angles and sequences them through a multi-cycle CORDIC unit
// Optional watchdog abort: CORDIC_INIT_TIMEOUT_EN
module cordic_batch_initiator #(
  parameter int FLOAT_DATA_WIDTH = cordic_pkg::FLOAT_DATA_WIDTH,
  parameter int FIFO_DEPTH       = 8
`ifdef CORDIC_INIT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES   = 64,
  parameter int COUNTER_WIDTH    = 10
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FLOAT_DATA_WIDTH-1:0] in_angle,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FLOAT_DATA_WIDTH-1:0] out_result,
  output logic                        out_err,
  output logic                        cu_clk_en,
  output logic [FLOAT_DATA_WIDTH-1:0] cu_angle_float,
  input  logic [FLOAT_DATA_WIDTH-1:0] cu_result,
  input  logic                        cu_done
);

  import cordic_pkg::*;

  localparam int COOL_W = $clog2(COOLDOWN_MIN + 1);

  state_e                      r_state;
  state_e                      w_next;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_issue;
  logic                        w_capture;
  logic                        w_timeout;
  logic [FLOAT_DATA_WIDTH-1:0] w_fifo_dout;
  logic [FLOAT_DATA_WIDTH-1:0] r_cu_angle;
  logic [FLOAT_DATA_WIDTH-1:0] r_out_result;
  logic                        r_out_valid;
  logic [COOL_W-1:0]           r_cool_cnt;

  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  sync_fifo #(
    .WIDTH (FLOAT_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_issue),
    .din   (in_angle),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A lingering cu_done (second done cycle, or one left over from before a reset) blocks issue.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!w_empty && !r_out_valid && !cu_done) w_next = WAIT_DONE;
      WAIT_DONE: if (cu_done || w_timeout) w_next = COOLDOWN;
      COOLDOWN:  if ((r_cool_cnt >= COOL_W'(COOLDOWN_MIN - 1)) && !cu_done) w_next = HOLD;
      HOLD:      if (!r_out_valid || out_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_issue   = (r_state == IDLE) && (w_next == WAIT_DONE);
    w_capture = (r_state == WAIT_DONE) && (w_next == COOLDOWN);
    cu_clk_en = (r_state == WAIT_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cu_angle   <= '0;
      r_out_result <= '0;
      r_out_valid  <= 1'b0;
      r_cool_cnt   <= '0;
    end else begin
      if (w_issue) r_cu_angle <= w_fifo_dout;
      if (w_capture) r_out_result <= w_timeout ? '0 : cu_result;
      if (w_capture)                       r_out_valid <= 1'b1;
      else if (r_out_valid && out_ready)   r_out_valid <= 1'b0;
      if (r_state == COOLDOWN) begin
        if (r_cool_cnt < COOL_W'(COOLDOWN_MIN - 1)) r_cool_cnt <= r_cool_cnt + 1'b1;
      end else begin
        r_cool_cnt <= '0;
      end
    end
  end

`ifdef CORDIC_INIT_TIMEOUT_EN
  logic [COUNTER_WIDTH-1:0] r_wd_cnt;
  logic                     r_out_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_out_err <= 1'b0;
    end else begin
      if (r_state == WAIT_DONE) r_wd_cnt <= r_wd_cnt + 1'b1;
      else                      r_wd_cnt <= '0;
      if (w_capture) r_out_err <= w_timeout;
    end
  end

  // Fires on the last permitted WAIT_DONE cycle so cu_clk_en stays high exactly TIMEOUT_CYCLES.
  assign w_timeout = (r_state == WAIT_DONE) && !cu_done &&
                     (r_wd_cnt == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1));
  assign out_err   = r_out_err;
`else
  assign w_timeout = 1'b0;
  assign out_err   = 1'b0;
`endif

  assign cu_angle_float = r_cu_angle;
  assign out_result     = r_out_result;
  assign out_valid      = r_out_valid;

endmodule

// File: tb/tb_cordic_batch_initiator.sv
// tb/tb_cordic_batch_initiator.sv - directed and random checks of the CORDIC batch initiator against a queue model
module tb_cordic_batch_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_angle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
  logic        cu_clk_en;
  logic [31:0] cu_angle_float;
  logic [31:0] cu_result;
  logic        cu_done;

  cordic_batch_initiator dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_angle       (in_angle),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_err        (out_err),
    .cu_clk_en      (cu_clk_en),
    .cu_angle_float (cu_angle_float),
    .cu_result      (cu_result),
    .cu_done        (cu_done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  logic [32:0] exp_q[$];
  bit          resp_en   = 1'b1;
  bit          resp_rand = 1'b0;
  int          resp_lat  = 27;
  int          resp_hold = 1;

  // Behaviour of the attached unit: cos(1.0) is known exactly, other angles map to a fixed scramble.
  function automatic logic [31:0] ref_cos(input logic [31:0] a);
    if (a == 32'h3F80_0000) return 32'h3F0A_5140;
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input int limit);
    int k = 0;
    while (out_valid !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("wait_out_valid", 33'(out_valid), 33'd1);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  // CORDIC unit responder
  initial begin : responder
    logic [31:0] ang;
    int          lat;
    int          hold;
    cu_done   = 1'b0;
    cu_result = '0;
    forever begin
      @(negedge clk);
      if (cu_clk_en === 1'b1 && resp_en) begin
        ang  = cu_angle_float;
        lat  = resp_rand ? int'($urandom_range(1, 12)) : resp_lat;
        hold = resp_rand ? int'($urandom_range(1, 2)) : resp_hold;
        for (int k = 1; k < lat; k++) begin
          @(negedge clk);
          if (cu_clk_en === 1'b1) chk("angle_stable", 33'(cu_angle_float), 33'(ang));
        end
        cu_result = ref_cos(ang);
        cu_done   = 1'b1;
        repeat (hold) @(negedge clk);
        cu_done   = 1'b0;
        cu_result = $urandom;
      end
    end
  end

  // Model: every accepted angle yields one result, in arrival order.
  logic        prev_ov  = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [31:0] prev_res = '0;
  logic        prev_en  = 1'b0;
  int          low_run  = 0;
  bit          seen_high = 1'b0;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      seen_high = 1'b0;
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back(resp_en ? {1'b0, ref_cos(in_angle)} : 33'h1_0000_0000);
      if (prev_ov && !prev_rdy && out_valid)
        chk("out_result_stable", 33'(out_result), 33'(prev_res));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 33'(exp_q.size()), 33'd1);
        end else begin
          chk("result", {out_err, out_result}, exp_q.pop_front());
          n_out++;
        end
      end
      if (cu_clk_en) begin
        if (!prev_en && seen_high) chk("cooldown_gap", 33'(low_run >= 2), 33'd1);
        low_run   = 0;
        seen_high = 1'b1;
      end else begin
        low_run++;
      end
    end
    prev_ov  = out_valid;
    prev_rdy = out_ready;
    prev_res = out_result;
    prev_en  = cu_clk_en;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int k;
    int n0;
    bit saw;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_angle  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  33'(in_ready),       33'd1);
    chk("rst_out_valid", 33'(out_valid),      33'd0);
    chk("rst_out_res",   33'(out_result),     33'd0);
    chk("rst_out_err",   33'(out_err),        33'd0);
    chk("rst_clk_en",    33'(cu_clk_en),      33'd0);
    chk("rst_cu_angle",  33'(cu_angle_float), 33'd0);
    rst = 1'b0;

    // cos(1.0) through an idle block, 27-cycle unit
    @(negedge clk);
    in_valid = 1'b1;
    in_angle = 32'h3F80_0000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("issue_push_plus1", 33'(cu_clk_en), 33'd0);
    @(negedge clk);
    chk("issue_push_plus2", 33'(cu_clk_en), 33'd1);
    chk("issue_angle", 33'(cu_angle_float), 33'h0_3F80_0000);
    k = 0;
    while (k < 100) begin
      #1;
      if (cu_done === 1'b1) break;
      @(negedge clk);
      k++;
    end
    chk("done_seen", 33'(cu_done), 33'd1);
    chk("ov_at_done", 33'(out_valid), 33'd0);
    @(negedge clk);
    chk("ov_after_done", 33'(out_valid), 33'd1);
    chk("cos1_result", 33'(out_result), 33'h0_3F0A_5140);
    chk("cos1_err", 33'(out_err), 33'd0);
    chk("clk_en_dropped", 33'(cu_clk_en), 33'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ov_drop_after_accept", 33'(out_valid), 33'd0);
    repeat (6) @(negedge clk);

    // negative angle passes through bit-exact
    in_valid = 1'b1;
    in_angle = 32'hBF80_0000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("neg_angle", 33'(cu_angle_float), 33'h0_BF80_0000);
    chk("neg_clk_en", 33'(cu_clk_en), 33'd1);
    wait_out(100);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // fill the FIFO behind a held result, then drain in order
    resp_rand = 1'b1;
    n0 = n_out;
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    in_angle = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(100);
    for (int i = 0; i < 8; i++) begin
      chk("in_ready_filling", 33'(in_ready), 33'd1);
      in_valid = 1'b1;
      in_angle = $urandom;
      @(negedge clk);
    end
    in_angle = $urandom;
    chk("in_ready_full", 33'(in_ready), 33'd0);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_no_issue", 33'(cu_clk_en), 33'd0);
    end
    chk("hold_still_valid", 33'(out_valid), 33'd1);
    out_ready = 1'b1;
    wait_drain(3000);
    chk("fill_result_count", 33'(n_out - n0), 33'd9);

    // random traffic on both sides
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 3);
      in_angle  = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain(3000);
    repeat (10) @(negedge clk);
    chk("random_idle_ov", 33'(out_valid), 33'd0);

    // reset during WAIT_DONE with angles buffered; the late done must be ignored
    resp_rand = 1'b0;
    resp_lat  = 27;
    resp_hold = 2;
    in_valid  = 1'b1;
    in_angle  = $urandom;
    repeat (3) begin
      @(negedge clk);
      in_angle = $urandom;
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_clk_en", 33'(cu_clk_en), 33'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("post_rst_clk_en",  33'(cu_clk_en), 33'd0);
    chk("post_rst_ov",      33'(out_valid), 33'd0);
    chk("post_rst_inready", 33'(in_ready),  33'd1);
    saw = 1'b0;
    k = 0;
    while (k < 60) begin
      #1;
      if (cu_done === 1'b1) break;
      if (out_valid || cu_clk_en) saw = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("late_done_seen", 33'(cu_done), 33'd1);
    chk("post_rst_quiet", 33'(saw), 33'd0);
    #1;
    in_valid = 1'b1;
    in_angle = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_blocks_issue", 33'(cu_clk_en), 33'd0);
    chk("late_done_no_out", 33'(out_valid), 33'd0);
    @(negedge clk);
    chk("issue_after_done_low", 33'(cu_clk_en), 33'd1);
    resp_hold = 1;
    wait_drain(200);

`ifdef CORDIC_INIT_TIMEOUT_EN
    // unit never answers: watchdog aborts after 64 cycles
    repeat (6) @(negedge clk);
    resp_en   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_angle  = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (cu_clk_en !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (cu_clk_en === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_len", 33'(k), 33'd64);
    wait_out(20);
    chk("timeout_err", 33'(out_err), 33'd1);
    chk("timeout_res", 33'(out_result), 33'd0);
    out_ready = 1'b1;
    wait_drain(20);
    resp_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
